apb_master_arbiter: RTL and testbench
=====================================

Name: apb_master_arbiter

Overview:
- Two-requester APB master that shares one APB bus between internal clients, e.g. the host configuration port (req0) and the weight/image loader (req1) of the cat recognizer.
- Runs the IDLE/SETUP/ACCESS protocol, holds address, data and direction stable per transfer, and waits on pready.
- Arbitrates round-robin and returns read data and error status with a one-cycle ack.
- Bounds every transfer with a timeout so a hung slave cannot stall either client.

Parameters:
ADDR_W, 16, APB address width
DATA_W, 32, APB data width
TIMEOUT, 16, max ACCESS cycles waiting for pready before abort (must be >= 2)

Ports:
pclock  in  1  APB clock, all state on rising edge
presetn  in  1  asynchronous active-low reset
req0  in  1  requester 0 transfer request, level
req0_write  in  1  requester 0 direction, 1=write
req0_addr  in  ADDR_W  requester 0 address
req0_wdata  in  DATA_W  requester 0 write data
ack0  out  1  one-cycle completion pulse to requester 0
req1  in  1  requester 1 transfer request, level
req1_write  in  1  requester 1 direction
req1_addr  in  ADDR_W  requester 1 address
req1_wdata  in  DATA_W  requester 1 write data
ack1  out  1  one-cycle completion pulse to requester 1
rdata  out  DATA_W  read data, valid with ackN
err  out  1  transfer error, valid with ackN
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
paddr  out  ADDR_W  APB address
pwdata  out  DATA_W  APB write data
prdata  in  DATA_W  APB read data
pready  in  1  APB ready
pslverr  in  1  APB slave error

Behaviour:
- Reset (async, presetn=0):
  - All outputs go to 0 immediately.
  - FSM goes to IDLE, timeout counter clears, last_grant=1, so requester 0 wins the first tie.
  - Reset mid-transfer abandons the transfer with no ack.
- Client handshake:
  - A client raises reqN with stable write/addr/wdata and holds them until ackN.
  - ackN is a registered 1-cycle pulse. The client may drop reqN in the ack cycle or keep it high for a new transfer.
  - Command fields are captured into internal registers at grant. Client changes after grant are ignored.
- FSM states IDLE, SETUP, ACCESS:
  - IDLE:
    - Selects a requester. If only one is requesting, it wins. If both, the one != last_grant wins.
    - A requester whose ackN is high in this cycle is ignored (no double issue).
    - On grant: capture the command, update last_grant, go to SETUP. Otherwise stay in IDLE.
    - psel=0, penable=0.
  - SETUP: psel=1, penable=0, paddr/pwrite/pwdata driven from the captured command. Always goes to ACCESS next cycle.
  - ACCESS:
    - psel=1, penable=1, same fields as SETUP.
    - On pready=1: go to IDLE. Next cycle ackN=1 for the owner, err=pslverr, rdata=prdata for reads and rdata=0 for writes.
    - Otherwise increment the timeout counter.
    - When TIMEOUT cycles have elapsed in ACCESS without pready: go to IDLE, drop psel/penable, and next cycle pulse ackN with err=1, rdata=0.
- psel, penable, paddr, pwrite and pwdata are registered outputs. paddr, pwrite and pwdata hold their last values in IDLE. rdata and err hold until the next ack.
- Timing:
  - Minimum latency with zero-wait slave: req seen at edge k; SETUP in cycle k+1; ACCESS in cycle k+2; ack in cycle k+3.
  - Back-to-back transfers take 3 cycles each (IDLE, SETUP, ACCESS).
- Never both ack0 and ack1 in one cycle. Never penable=1 without psel=1. penable is always preceded by exactly one SETUP cycle.

Test Plan:
- req0 write addr=0x0010 data=0xCAFEF00D, pready tied 1 -> psel one cycle before penable; paddr=0x0010, pwrite=1, pwdata=0xCAFEF00D; ack0 pulses 3 cycles after req0 is sampled; err=0.
- req1 read addr=0x0020, pready low for 3 ACCESS cycles then high with prdata=0x12345678 -> ACCESS held 4 cycles; ack1 with rdata=0x12345678, err=0.
- req0 and req1 asserted together from reset and held -> grant order 0,1,0,1; ack0 and ack1 never coincide; no transfer is issued twice per request.
- Read with pslverr=1 on pready -> ackN with err=1, rdata=prdata. Slave never asserts pready -> after 16 ACCESS cycles psel/penable drop, ackN with err=1, rdata=0.
- presetn low during ACCESS -> psel, penable, ack0, ack1, err and rdata are 0 immediately. After release, a pending req0 and req1 restart with requester 0 granted first.

Source files
------------

// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter
//   Shares one APB bus between two internal requesters (for example the host
//   configuration port on req0 and the weight/image loader on req1). It
//   arbitrates round-robin, runs the IDLE/SETUP/ACCESS protocol and returns
//   read data and error status with a one-cycle ack. Every transfer has a
//   timeout, so a hung slave cannot stall either client.
//
// Ports
//   pclock, presetn           clock (rising edge) and async active-low reset
//   reqN, reqN_write,         requester N command: level request, direction
//   reqN_addr, reqN_wdata     (1 = write), address and write data
//   ackN                      one-cycle completion pulse to requester N
//   rdata, err                read data / error status, valid with ackN,
//                             held until the next ack
//   psel, penable, pwrite,    APB master outputs, all registered
//   paddr, pwdata
//   prdata, pready, pslverr   APB slave response
//
// Client handshake (req/ack):
//   A client raises reqN together with stable reqN_write/addr/wdata and holds
//   them until ackN. The command is copied into the APB registers when the
//   request is granted, so later changes from the client have no effect.
//   ackN is a single-cycle registered pulse. During the ack cycle the
//   arbiter ignores reqN, so the client may either drop reqN then or keep it
//   high to request a new transfer. A request still high in the ack cycle is
//   seen from the next cycle on, and no transfer is issued twice.
module apb_master_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              pclock,
  input  logic              presetn,
  input  logic              req0,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              ack0,
  input  logic              req1,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t           state;
  logic             last_grant;  // requester granted most recently
  logic             owner;       // requester owning the current transfer
  logic [CNT_W-1:0] tmo_cnt;     // ACCESS cycles spent without pready

  // A requester in its ack cycle is masked so a level request that the
  // client has not yet dropped does not start a second transfer.
  logic r0_live;
  logic r1_live;
  logic grant_valid;
  logic grant_sel;

  always_comb begin
    r0_live     = req0 & ~ack0;
    r1_live     = req1 & ~ack1;
    grant_valid = r0_live | r1_live;
    grant_sel   = 1'b0;
    if (r0_live && r1_live) begin
      grant_sel = ~last_grant;
    end else if (r1_live) begin
      grant_sel = 1'b1;
    end
  end

  always_ff @(posedge pclock or negedge presetn) begin
    if (!presetn) begin
      state      <= S_IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      tmo_cnt    <= '0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      rdata      <= '0;
      err        <= 1'b0;
      psel       <= 1'b0;
      penable    <= 1'b0;
      pwrite     <= 1'b0;
      paddr      <= '0;
      pwdata     <= '0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant_valid) begin
            // paddr/pwrite/pwdata double as the captured command registers.
            owner      <= grant_sel;
            last_grant <= grant_sel;
            pwrite     <= grant_sel ? req1_write : req0_write;
            paddr      <= grant_sel ? req1_addr  : req0_addr;
            pwdata     <= grant_sel ? req1_wdata : req0_wdata;
            psel       <= 1'b1;
            penable    <= 1'b0;
            state      <= S_SETUP;
          end
        end
        S_SETUP: begin
          penable <= 1'b1;
          tmo_cnt <= '0;
          state   <= S_ACCESS;
        end
        S_ACCESS: begin
          if (pready) begin
            psel    <= 1'b0;
            penable <= 1'b0;
            ack0    <= ~owner;
            ack1    <= owner;
            err     <= pslverr;
            rdata   <= pwrite ? '0 : prdata;
            tmo_cnt <= '0;
            state   <= S_IDLE;
          end else if (tmo_cnt == CNT_LAST) begin
            // TIMEOUT ACCESS cycles without pready: abort with an error.
            psel    <= 1'b0;
            penable <= 1'b0;
            ack0    <= ~owner;
            ack1    <= owner;
            err     <= 1'b1;
            rdata   <= '0;
            tmo_cnt <= '0;
            state   <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: begin
          psel    <= 1'b0;
          penable <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed testbench for apb_master_arbiter. Inputs change 1 ns after the
// rising edge and outputs are sampled at that same point.
module tb_apb_master_arbiter;

  logic        pclock = 1'b0;
  logic        presetn = 1'b0;
  logic        req0 = 1'b0;
  logic        req0_write = 1'b0;
  logic [15:0] req0_addr = '0;
  logic [31:0] req0_wdata = '0;
  logic        ack0;
  logic        req1 = 1'b0;
  logic        req1_write = 1'b0;
  logic [15:0] req1_addr = '0;
  logic [31:0] req1_wdata = '0;
  logic        ack1;
  logic [31:0] rdata;
  logic        err;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [15:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata = '0;
  logic        pready = 1'b0;
  logic        pslverr = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  apb_master_arbiter #(.ADDR_W(16), .DATA_W(32), .TIMEOUT(16)) dut (
    .pclock     (pclock),
    .presetn    (presetn),
    .req0       (req0),
    .req0_write (req0_write),
    .req0_addr  (req0_addr),
    .req0_wdata (req0_wdata),
    .ack0       (ack0),
    .req1       (req1),
    .req1_write (req1_write),
    .req1_addr  (req1_addr),
    .req1_wdata (req1_wdata),
    .ack1       (ack1),
    .rdata      (rdata),
    .err        (err),
    .psel       (psel),
    .penable    (penable),
    .pwrite     (pwrite),
    .paddr      (paddr),
    .pwdata     (pwdata),
    .prdata     (prdata),
    .pready     (pready),
    .pslverr    (pslverr)
  );

  // Clock / reset
  always #5 pclock = ~pclock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge pclock);
    #1;
  endtask

  task automatic test_reset();
    presetn = 1'b0;
    #3;
    if ({ack0, ack1, err, psel, penable, pwrite, paddr, pwdata, rdata} !== 86'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h expected 0",
               {ack0, ack1, err, psel, penable, pwrite, paddr, pwdata, rdata});
    end
    vectors++;
    tick();
    tick();
    presetn = 1'b1;
    tick();
    if ({psel, penable, ack0, ack1} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_idle: got %b expected 0000", {psel, penable, ack0, ack1});
    end
    vectors++;
  endtask

  task automatic test_write0();
    req0 = 1'b1; req0_write = 1'b1; req0_addr = 16'h0010; req0_wdata = 32'hCAFEF00D;
    pready = 1'b1; pslverr = 1'b0;
    tick();  // SETUP
    if ({ack0, psel, penable, pwrite, paddr, pwdata} !== {1'b0, 1'b1, 1'b0, 1'b1, 16'h0010, 32'hCAFEF00D}) begin
      miscompares++;
      $display("FAIL write0_setup: got %h expected %h", {ack0, psel, penable, pwrite, paddr, pwdata},
               {1'b0, 1'b1, 1'b0, 1'b1, 16'h0010, 32'hCAFEF00D});
    end
    vectors++;
    // Client changes after grant must not reach the bus.
    req0_addr = 16'hFFFF; req0_wdata = 32'h0;
    tick();  // ACCESS
    if ({ack0, psel, penable, pwrite, paddr, pwdata} !== {1'b0, 1'b1, 1'b1, 1'b1, 16'h0010, 32'hCAFEF00D}) begin
      miscompares++;
      $display("FAIL write0_access: got %h expected %h", {ack0, psel, penable, pwrite, paddr, pwdata},
               {1'b0, 1'b1, 1'b1, 1'b1, 16'h0010, 32'hCAFEF00D});
    end
    vectors++;
    tick();  // ack cycle, req0 deliberately still high
    if ({ack0, ack1, err, psel, penable, rdata} !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0}) begin
      miscompares++;
      $display("FAIL write0_ack: got %h expected %h", {ack0, ack1, err, psel, penable, rdata},
               {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0});
    end
    vectors++;
    tick();
    req0 = 1'b0;
    if ({ack0, psel} !== 2'b00) begin
      miscompares++;
      $display("FAIL write0_no_reissue: got %b expected 00", {ack0, psel});
    end
    vectors++;
    pready = 1'b0;
    tick();
  endtask

  task automatic test_read1_wait();
    req1 = 1'b1; req1_write = 1'b0; req1_addr = 16'h0020; req1_wdata = 32'h0;
    pready = 1'b0;
    tick();  // SETUP
    if ({ack1, psel, penable, pwrite, paddr} !== {1'b0, 1'b1, 1'b0, 1'b0, 16'h0020}) begin
      miscompares++;
      $display("FAIL read1_setup: got %h expected %h", {ack1, psel, penable, pwrite, paddr},
               {1'b0, 1'b1, 1'b0, 1'b0, 16'h0020});
    end
    vectors++;
    tick();
    for (int i = 0; i < 4; i++) begin
      if ({psel, penable, ack1} !== 3'b110) begin
        miscompares++;
        $display("FAIL read1_access_%0d: got %b expected 110", i, {psel, penable, ack1});
      end
      vectors++;
      if (i == 3) begin
        pready = 1'b1; prdata = 32'h12345678;
      end
      tick();
    end
    if ({ack1, ack0, err, psel, penable, rdata} !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h12345678}) begin
      miscompares++;
      $display("FAIL read1_ack: got %h expected %h", {ack1, ack0, err, psel, penable, rdata},
               {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h12345678});
    end
    vectors++;
    req1 = 1'b0; pready = 1'b0; prdata = 32'h0;
    tick();
  endtask

  task automatic test_timeout();
    req1 = 1'b1; req1_write = 1'b1; req1_addr = 16'h0040; req1_wdata = 32'h11112222;
    pready = 1'b0; prdata = 32'hBADBAD00;
    tick();  // SETUP
    for (int i = 0; i < 16; i++) begin
      tick();
      if ({psel, penable, ack1} !== 3'b110) begin
        miscompares++;
        $display("FAIL timeout_access_%0d: got %b expected 110", i, {psel, penable, ack1});
      end
      vectors++;
    end
    tick();
    if ({ack1, err, rdata, psel, penable} !== {1'b1, 1'b1, 32'h0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL timeout_abort: got %h expected %h", {ack1, err, rdata, psel, penable},
               {1'b1, 1'b1, 32'h0, 1'b0, 1'b0});
    end
    vectors++;
    req1 = 1'b0; prdata = 32'h0;
    tick();
  endtask

  task automatic test_pslverr();
    req0 = 1'b1; req0_write = 1'b0; req0_addr = 16'h0030;
    pready = 1'b1; pslverr = 1'b1; prdata = 32'hDEADBEEF;
    tick();  // SETUP
    tick();  // ACCESS
    tick();  // ack
    if ({ack0, err, rdata} !== {1'b1, 1'b1, 32'hDEADBEEF}) begin
      miscompares++;
      $display("FAIL pslverr_ack: got %h expected %h", {ack0, err, rdata}, {1'b1, 1'b1, 32'hDEADBEEF});
    end
    vectors++;
    req0 = 1'b0; pready = 1'b0; pslverr = 1'b0; prdata = 32'h0;
    tick();
    if ({ack0, err, rdata, psel} !== {1'b0, 1'b1, 32'hDEADBEEF, 1'b0}) begin
      miscompares++;
      $display("FAIL pslverr_hold: got %h expected %h", {ack0, err, rdata, psel},
               {1'b0, 1'b1, 32'hDEADBEEF, 1'b0});
    end
    vectors++;
  endtask

  task automatic test_round_robin();
    logic [15:0] exp_addr;
    presetn = 1'b0;
    req0 = 1'b1; req0_write = 1'b1; req0_addr = 16'h0100; req0_wdata = 32'hA0A0A0A0;
    req1 = 1'b1; req1_write = 1'b0; req1_addr = 16'h0200; req1_wdata = 32'h0;
    pready = 1'b1; prdata = 32'h55AA55AA;
    tick();
    tick();
    presetn = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (ack0 && ack1) begin
        miscompares++;
        $display("FAIL rr_dual_ack_%0d: got ack0=1 ack1=1 expected at most one", i);
      end
      vectors++;
      if (i % 3 == 1) begin
        exp_addr = (((i - 1) / 3) % 2 == 0) ? 16'h0100 : 16'h0200;
        if ({psel, penable, paddr} !== {1'b1, 1'b0, exp_addr}) begin
          miscompares++;
          $display("FAIL rr_setup_%0d: got %h expected %h", i, {psel, penable, paddr},
                   {1'b1, 1'b0, exp_addr});
        end
        vectors++;
      end
      if (i % 3 == 0) begin
        if (((i / 3) % 2) == 1) begin
          if ({ack0, ack1, rdata} !== {2'b10, 32'h0}) begin
            miscompares++;
            $display("FAIL rr_ack0_%0d: got %h expected %h", i, {ack0, ack1, rdata}, {2'b10, 32'h0});
          end
        end else begin
          if ({ack0, ack1, rdata} !== {2'b01, 32'h55AA55AA}) begin
            miscompares++;
            $display("FAIL rr_ack1_%0d: got %h expected %h", i, {ack0, ack1, rdata},
                     {2'b01, 32'h55AA55AA});
          end
        end
        vectors++;
      end
    end
    req0 = 1'b0; req1 = 1'b0; pready = 1'b0; prdata = 32'h0;
    tick();
  endtask

  task automatic test_reset_mid();
    req0 = 1'b1; req0_write = 1'b1; req0_addr = 16'h0050; req0_wdata = 32'h0BADF00D;
    req1 = 1'b1; req1_write = 1'b0; req1_addr = 16'h0060;
    pready = 1'b0; prdata = 32'h77778888;
    tick();  // SETUP for req0
    tick();  // ACCESS
    tick();  // ACCESS, waiting
    presetn = 1'b0;
    #1;
    if ({psel, penable, ack0, ack1, err, rdata} !== 37'd0) begin
      miscompares++;
      $display("FAIL midreset_outputs: got %h expected 0", {psel, penable, ack0, ack1, err, rdata});
    end
    vectors++;
    tick();
    tick();
    presetn = 1'b1;
    tick();
    if ({psel, penable, paddr, pwrite} !== {1'b1, 1'b0, 16'h0050, 1'b1}) begin
      miscompares++;
      $display("FAIL midreset_first_grant: got %h expected %h", {psel, penable, paddr, pwrite},
               {1'b1, 1'b0, 16'h0050, 1'b1});
    end
    vectors++;
    pready = 1'b1;
    tick();
    tick();
    if ({ack0, ack1} !== 2'b10) begin
      miscompares++;
      $display("FAIL midreset_ack0: got %b expected 10", {ack0, ack1});
    end
    vectors++;
    req0 = 1'b0;
    tick();
    if ({psel, penable, paddr, pwrite} !== {1'b1, 1'b0, 16'h0060, 1'b0}) begin
      miscompares++;
      $display("FAIL midreset_second_grant: got %h expected %h", {psel, penable, paddr, pwrite},
               {1'b1, 1'b0, 16'h0060, 1'b0});
    end
    vectors++;
    tick();
    tick();
    if ({ack1, err, rdata} !== {1'b1, 1'b0, 32'h77778888}) begin
      miscompares++;
      $display("FAIL midreset_ack1: got %h expected %h", {ack1, err, rdata}, {1'b1, 1'b0, 32'h77778888});
    end
    vectors++;
    req1 = 1'b0; pready = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_write0();
    test_read1_wait();
    test_timeout();
    test_pslverr();
    test_round_robin();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
